coherence_bus_arbiter: RTL and testbench

- Shared snooping-bus controller between `NUM_CORES` L1 MESI caches and the L2.
- Grants the bus round-robin to one requesting core and samples that core's bus operation and address.
- Broadcasts the operation to all other L1s as a snoop, then returns data and the shared/exclusive indication to the requester.
- Sources that data from a snooping cache or an L2 read, and writes flushed lines back to L2.

---
 rtl/coherence_bus_pkg.sv | 31 +++
 rtl/coherence_bus_arbiter_if.sv | 47 ++++
 rtl/coherence_bus_arbiter_rr.sv | 37 +++
 rtl/coherence_bus_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_coherence_bus_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coherence_bus_pkg.sv
// ---------------------------------------------------------------------------
// coherence_bus_pkg
// Shared types and constants for the snooping coherence bus controller.
//   bus_op_t     : bus operation encoding carried on core_op / snoop_op
//   arb_state_t  : bus controller FSM states
//   RESP_*       : encodings of resp_shared returned to the requesting core
// ---------------------------------------------------------------------------
package coherence_bus_pkg;

    typedef enum logic [1:0] {
        BUS_RD   = 2'b00,
        BUS_UPGR = 2'b01,
        BUS_RDX  = 2'b10,
        BUS_NONE = 2'b11
    } bus_op_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        SNOOP     = 3'd2,
        L2_READ   = 3'd3,
        WRITEBACK = 3'd4,
        RESP      = 3'd5,
        RELEASE   = 3'd6
    } arb_state_t;

    localparam logic [1:0] RESP_NONE   = 2'b00;
    localparam logic [1:0] RESP_SHARED = 2'b01;
    localparam logic [1:0] RESP_EXCL   = 2'b10;

endpackage

// File: rtl/coherence_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// coherence_bus_arbiter_if
// Bundle of every signal between the bus controller, the L1 caches and L2.
//   master : the bus controller (drives grant, snoop, response and L2 requests)
//   slave  : the cache/L2 side (drives requests, snoop replies and L2 replies)
// Per-core fields are packed arrays indexed by core number.
// ---------------------------------------------------------------------------
interface coherence_bus_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);

    logic [NUM_CORES-1:0]             req;
    logic [NUM_CORES-1:0]             grant;
    logic [NUM_CORES-1:0][1:0]        core_op;
    logic [NUM_CORES-1:0][ADDR_W-1:0] core_addr;
    logic [NUM_CORES-1:0][1:0]        snoop_op;
    logic [ADDR_W-1:0]                snoop_addr;
    logic [NUM_CORES-1:0]             snoop_hit;
    logic [NUM_CORES-1:0]             snoop_flush;
    logic [NUM_CORES-1:0][DATA_W-1:0] snoop_data;
    logic                             resp_valid;
    logic [DATA_W-1:0]                resp_data;
    logic [1:0]                       resp_shared;
    logic                             l2_rd_req;
    logic                             l2_wr_req;
    logic [ADDR_W-1:0]                l2_addr;
    logic [DATA_W-1:0]                l2_wdata;
    logic [DATA_W-1:0]                l2_rdata;
    logic                             l2_ack;

    modport master (
        input  req, core_op, core_addr, snoop_hit, snoop_flush, snoop_data,
               l2_rdata, l2_ack,
        output grant, snoop_op, snoop_addr, resp_valid, resp_data, resp_shared,
               l2_rd_req, l2_wr_req, l2_addr, l2_wdata
    );

    modport slave (
        output req, core_op, core_addr, snoop_hit, snoop_flush, snoop_data,
               l2_rdata, l2_ack,
        input  grant, snoop_op, snoop_addr, resp_valid, resp_data, resp_shared,
               l2_rd_req, l2_wr_req, l2_addr, l2_wdata
    );

endinterface

// File: rtl/coherence_bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The search starts at rr_ptr and wraps;
// the first requesting core found gets the single set bit of grant.
//   req    : per-core request vector
//   rr_ptr : index of the highest-priority core this round
//   grant  : one-hot winner (all zero when nothing requests)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [NUM_CORES-1:0] grant
);

    logic             found_s;
    logic [IDX_W-1:0] idx_s;

    // Walk the cores in priority order from rr_ptr and keep the first requester.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx_s = IDX_W'((int'(rr_ptr) + i) % NUM_CORES);
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// ---------------------------------------------------------------------------
// coherence_bus_arbiter
// Snooping-bus controller shared by NUM_CORES L1 MESI caches and the L2.
// One transaction at a time: grant a core round-robin, latch its op/address,
// broadcast the snoop to the other caches, then source the fill from the
// lowest-index hitting cache (writing its flushed line back to L2 first when
// it flushes) or from an L2 read, and strobe the response to the owner.
//   clk, reset : clock, synchronous active-high reset
//   bus        : master side of coherence_bus_arbiter_if (all bus signals)
// Every output is driven straight from a register.
// ---------------------------------------------------------------------------
module coherence_bus_arbiter
    import coherence_bus_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input logic                      clk,
    input logic                      reset,
    coherence_bus_arbiter_if.master  bus
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    arb_state_t                state_r;
    logic [NUM_CORES-1:0]      grant_r;
    logic [IDX_W-1:0]          owner_r;
    logic [IDX_W-1:0]          rr_ptr_r;
    bus_op_t                   op_r;
    logic [ADDR_W-1:0]         addr_r;
    logic [NUM_CORES-1:0][1:0] snoop_op_r;
    logic [ADDR_W-1:0]         snoop_addr_r;
    logic                      resp_valid_r;
    logic [DATA_W-1:0]         resp_data_r;
    logic [1:0]                resp_shared_r;
    logic                      l2_rd_req_r;
    logic                      l2_wr_req_r;
    logic [ADDR_W-1:0]         l2_addr_r;
    logic [DATA_W-1:0]         l2_wdata_r;

    logic [NUM_CORES-1:0]      pick_s;
    logic [IDX_W-1:0]          pick_idx_s;
    logic [IDX_W-1:0]          next_ptr_s;
    bus_op_t                   owner_op_s;
    logic [ADDR_W-1:0]         owner_addr_s;
    logic [NUM_CORES-1:0][1:0] snoop_fan_s;
    logic [DATA_W-1:0]         hit_data_s;
    logic [DATA_W-1:0]         flush_data_s;

    rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_rr_arbiter (
        .req    (bus.req),
        .rr_ptr (rr_ptr_r),
        .grant  (pick_s)
    );

    // Encode the one-hot pick into the owner index.
    always_comb begin
        pick_idx_s = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            pick_idx_s = pick_s[i] ? IDX_W'(i) : pick_idx_s;
        end
    end

    // Owner's request fields, the snoop fan-out (owner never snoops itself)
    // and the priority pointer the next round starts from.
    always_comb begin
        owner_op_s   = bus_op_t'(bus.core_op[owner_r]);
        owner_addr_s = bus.core_addr[owner_r];
        next_ptr_s   = (owner_r == IDX_W'(NUM_CORES - 1)) ? IDX_W'(0) : owner_r + IDX_W'(1);
        for (int i = 0; i < NUM_CORES; i++) begin
            snoop_fan_s[i] = (IDX_W'(i) == owner_r) ? BUS_NONE : owner_op_s;
        end
    end

    // Lowest-index hitting / flushing cache supplies the data (descending scan
    // so the lowest index is written last and wins).
    always_comb begin
        hit_data_s   = '0;
        flush_data_s = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            hit_data_s   = bus.snoop_hit[i]   ? bus.snoop_data[i] : hit_data_s;
            flush_data_s = bus.snoop_flush[i] ? bus.snoop_data[i] : flush_data_s;
        end
    end

    // Transaction FSM with all bus outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            grant_r       <= '0;
            owner_r       <= '0;
            rr_ptr_r      <= '0;
            op_r          <= BUS_NONE;
            addr_r        <= '0;
            snoop_op_r    <= {NUM_CORES{2'b11}};
            snoop_addr_r  <= '0;
            resp_valid_r  <= 1'b0;
            resp_data_r   <= '0;
            resp_shared_r <= RESP_NONE;
            l2_rd_req_r   <= 1'b0;
            l2_wr_req_r   <= 1'b0;
            l2_addr_r     <= '0;
            l2_wdata_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|bus.req) begin
                        grant_r <= pick_s;
                        owner_r <= pick_idx_s;
                        state_r <= GRANT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    op_r   <= owner_op_s;
                    addr_r <= owner_addr_s;
                    if (owner_op_s == BUS_NONE) begin
                        grant_r <= '0;
                        state_r <= RELEASE;
                    end else begin
                        snoop_op_r   <= snoop_fan_s;
                        snoop_addr_r <= owner_addr_s;
                        state_r      <= SNOOP;
                    end
                end
                SNOOP: begin
                    // The snoop is broadcast for exactly this one cycle.
                    snoop_op_r <= {NUM_CORES{2'b11}};
                    if (op_r == BUS_UPGR) begin
                        resp_valid_r  <= 1'b1;
                        resp_data_r   <= '0;
                        resp_shared_r <= RESP_NONE;
                        state_r       <= RESP;
                    end else if (|bus.snoop_hit) begin
                        resp_data_r   <= hit_data_s;
                        resp_shared_r <= RESP_SHARED;
                        if (|bus.snoop_flush) begin
                            l2_wr_req_r <= 1'b1;
                            l2_addr_r   <= addr_r;
                            l2_wdata_r  <= flush_data_s;
                            state_r     <= WRITEBACK;
                        end else begin
                            resp_valid_r <= 1'b1;
                            state_r      <= RESP;
                        end
                    end else begin
                        l2_rd_req_r <= 1'b1;
                        l2_addr_r   <= addr_r;
                        state_r     <= L2_READ;
                    end
                end
                L2_READ: begin
                    if (bus.l2_ack) begin
                        l2_rd_req_r   <= 1'b0;
                        resp_data_r   <= bus.l2_rdata;
                        resp_shared_r <= RESP_EXCL;
                        resp_valid_r  <= 1'b1;
                        state_r       <= RESP;
                    end else begin
                        state_r <= L2_READ;
                    end
                end
                WRITEBACK: begin
                    if (bus.l2_ack) begin
                        l2_wr_req_r  <= 1'b0;
                        resp_valid_r <= 1'b1;
                        state_r      <= RESP;
                    end else begin
                        state_r <= WRITEBACK;
                    end
                end
                RESP: begin
                    resp_valid_r <= 1'b0;
                    grant_r      <= '0;
                    state_r      <= RELEASE;
                end
                RELEASE: begin
                    rr_ptr_r <= next_ptr_s;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = grant_r;
    assign bus.snoop_op    = snoop_op_r;
    assign bus.snoop_addr  = snoop_addr_r;
    assign bus.resp_valid  = resp_valid_r;
    assign bus.resp_data   = resp_data_r;
    assign bus.resp_shared = resp_shared_r;
    assign bus.l2_rd_req   = l2_rd_req_r;
    assign bus.l2_wr_req   = l2_wr_req_r;
    assign bus.l2_addr     = l2_addr_r;
    assign bus.l2_wdata    = l2_wdata_r;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_coherence_bus_arbiter
// Self-checking bench for coherence_bus_arbiter: directed scenarios followed
// by random transactions, each checked cycle by cycle against a
// transaction-level reference model (round-robin pick, snoop resolution and
// expected response) held in the bench.
// ---------------------------------------------------------------------------
module tb_coherence_bus_arbiter;

    localparam int N = 4;
    localparam int A = 32;
    localparam int D = 32;

    logic clk;
    logic reset;

    coherence_bus_arbiter_if #(.NUM_CORES(N), .ADDR_W(A), .DATA_W(D)) bus ();

    coherence_bus_arbiter #(.NUM_CORES(N), .ADDR_W(A), .DATA_W(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int model_rr = 0;

    // stimulus for one transaction
    logic [N-1:0] s_req;
    logic [1:0]   s_op   [N];
    logic [A-1:0] s_addr [N];
    logic [D-1:0] s_data [N];
    logic [N-1:0] s_hit;
    logic [N-1:0] s_flush;
    int           s_delay;
    logic [D-1:0] s_rdata;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference round-robin: first requester at or after ptr
    function automatic int model_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_reset_vals();
        check_eq("rst_grant", 64'(bus.grant), 64'(0));
        for (int k = 0; k < N; k++) check_eq("rst_snoop_op", 64'(bus.snoop_op[k]), 64'(3));
        check_eq("rst_snoop_addr", 64'(bus.snoop_addr), 64'(0));
        check_eq("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        check_eq("rst_resp_data", 64'(bus.resp_data), 64'(0));
        check_eq("rst_resp_shared", 64'(bus.resp_shared), 64'(0));
        check_eq("rst_l2_rd_req", 64'(bus.l2_rd_req), 64'(0));
        check_eq("rst_l2_wr_req", 64'(bus.l2_wr_req), 64'(0));
        check_eq("rst_l2_addr", 64'(bus.l2_addr), 64'(0));
        check_eq("rst_l2_wdata", 64'(bus.l2_wdata), 64'(0));
    endtask

    task automatic clear_inputs();
        bus.req = '0;
        bus.core_op = '1;
        bus.core_addr = '0;
        bus.snoop_hit = '0;
        bus.snoop_flush = '0;
        bus.snoop_data = '0;
        bus.l2_rdata = '0;
        bus.l2_ack = 1'b0;
    endtask

    task automatic randomize_stim();
        s_req = N'($urandom_range(1, (1 << N) - 1));
        for (int k = 0; k < N; k++) begin
            s_op[k]   = 2'($urandom_range(0, 3));
            s_addr[k] = A'($urandom);
            s_data[k] = D'($urandom);
        end
        s_hit   = N'($urandom_range(0, (1 << N) - 1));
        s_flush = N'($urandom_range(0, (1 << N) - 1));
        s_delay = $urandom_range(0, 3);
        s_rdata = D'($urandom);
    endtask

    // One full transaction starting with the DUT idle; returns with it idle.
    task automatic run_txn();
        int           w;
        int           hi;
        int           fi;
        int           path;   // 1 direct response, 2 writeback, 3 L2 read
        logic [1:0]   op;
        logic [A-1:0] ad;
        logic [N-1:0] hit;
        logic [N-1:0] fl;
        logic [D-1:0] exp_data;
        logic [D-1:0] exp_wdata;
        logic [1:0]   exp_sh;

        w   = model_pick(s_req, model_rr);
        op  = s_op[w];
        ad  = s_addr[w];
        hit = s_hit;
        hit[w] = 1'b0;
        fl  = s_flush;
        fl[w] = 1'b0;

        bus.req = s_req;
        for (int k = 0; k < N; k++) begin
            bus.core_op[k]   = s_op[k];
            bus.core_addr[k] = s_addr[k];
        end
        tick();
        check_eq("grant", 64'(bus.grant), 64'(1) << w);
        bus.req = '0;
        tick();
        if (op == 2'b11) begin
            check_eq("noop_grant_drop", 64'(bus.grant), 64'(0));
            check_eq("noop_resp_valid", 64'(bus.resp_valid), 64'(0));
            tick();
            check_eq("noop_idle_resp", 64'(bus.resp_valid), 64'(0));
        end else begin
            for (int k = 0; k < N; k++)
                check_eq("snoop_op", 64'(bus.snoop_op[k]), (k == w) ? 64'(3) : 64'(op));
            check_eq("snoop_addr", 64'(bus.snoop_addr), 64'(ad));
            check_eq("grant_hold", 64'(bus.grant), 64'(1) << w);
            bus.snoop_hit   = hit;
            bus.snoop_flush = fl;
            for (int k = 0; k < N; k++) bus.snoop_data[k] = s_data[k];
            bus.l2_ack   = 1'($urandom_range(0, 1));
            bus.l2_rdata = D'($urandom);
            tick();
            bus.snoop_hit   = '0;
            bus.snoop_flush = '0;
            bus.snoop_data  = '0;
            bus.l2_ack      = 1'b0;
            for (int k = 0; k < N; k++) check_eq("snoop_one_cycle", 64'(bus.snoop_op[k]), 64'(3));

            exp_wdata = '0;
            if (op == 2'b01) begin
                path = 1; exp_data = '0; exp_sh = 2'b00;
            end else if (hit != '0) begin
                hi = 0;
                for (int k = N - 1; k >= 0; k--) if (hit[k]) hi = k;
                exp_data = s_data[hi];
                exp_sh   = 2'b01;
                if (fl != '0) begin
                    fi = 0;
                    for (int k = N - 1; k >= 0; k--) if (fl[k]) fi = k;
                    exp_wdata = s_data[fi];
                    path = 2;
                end else begin
                    path = 1;
                end
            end else begin
                path = 3; exp_data = s_rdata; exp_sh = 2'b10;
            end

            if (path != 1) begin
                check_eq("l2_rd_req", 64'(bus.l2_rd_req), (path == 3) ? 64'(1) : 64'(0));
                check_eq("l2_wr_req", 64'(bus.l2_wr_req), (path == 2) ? 64'(1) : 64'(0));
                check_eq("l2_addr", 64'(bus.l2_addr), 64'(ad));
                if (path == 2) check_eq("l2_wdata", 64'(bus.l2_wdata), 64'(exp_wdata));
                check_eq("resp_early", 64'(bus.resp_valid), 64'(0));
                for (int d = 0; d < s_delay; d++) begin
                    tick();
                    check_eq("l2_req_held", 64'(bus.l2_rd_req | bus.l2_wr_req), 64'(1));
                    check_eq("resp_wait", 64'(bus.resp_valid), 64'(0));
                    check_eq("grant_wait", 64'(bus.grant), 64'(1) << w);
                end
                bus.l2_ack   = 1'b1;
                bus.l2_rdata = s_rdata;
                tick();
                bus.l2_ack   = 1'b0;
                bus.l2_rdata = '0;
            end
            check_eq("resp_valid", 64'(bus.resp_valid), 64'(1));
            check_eq("resp_data", 64'(bus.resp_data), 64'(exp_data));
            check_eq("resp_shared", 64'(bus.resp_shared), 64'(exp_sh));
            check_eq("l2_req_idle", 64'(bus.l2_rd_req | bus.l2_wr_req), 64'(0));
            check_eq("grant_resp", 64'(bus.grant), 64'(1) << w);
            tick();
            check_eq("resp_one_cycle", 64'(bus.resp_valid), 64'(0));
            check_eq("grant_release", 64'(bus.grant), 64'(0));
            tick();
        end
        model_rr = (w + 1) % N;
    endtask

    initial begin
        int            seen[$];
        logic [N-1:0]  prev;
        int            g;
        int            ptr;

        clear_inputs();
        reset = 1'b1;
        repeat (3) tick();
        check_reset_vals();
        reset = 1'b0;
        tick();

        // single read miss: core1 BusRd 0x40, L2 ack after 3 cycles
        randomize_stim();
        s_req = 4'b0010; s_op[1] = 2'b00; s_addr[1] = 32'h0000_0040;
        s_hit = '0; s_flush = '0; s_delay = 3; s_rdata = 32'hDEAD_BEEF;
        run_txn();

        // flush path: core0 BusRd, core2 hit+flush
        randomize_stim();
        s_req = 4'b0001; s_op[0] = 2'b00; s_hit = 4'b0100; s_flush = 4'b0100;
        s_data[2] = 32'h1234_5678; s_delay = 1;
        run_txn();

        // upgrade from core3
        randomize_stim();
        s_req = 4'b1000; s_op[3] = 2'b01; s_hit = '0; s_flush = '0;
        run_txn();

        // no-op grant from core2
        randomize_stim();
        s_req = 4'b0100; s_op[2] = 2'b11;
        run_txn();

        // random transactions
        for (int t = 0; t < 40; t++) begin
            randomize_stim();
            run_txn();
        end

        // reset during L2_READ, then a late ack
        randomize_stim();
        s_op[2] = 2'b00;
        bus.req = 4'b0100;
        for (int k = 0; k < N; k++) begin
            bus.core_op[k]   = s_op[k];
            bus.core_addr[k] = s_addr[k];
        end
        tick();
        bus.req = '0;
        tick();
        tick();
        check_eq("abort_in_l2_read", 64'(bus.l2_rd_req), 64'(1));
        reset = 1'b1;
        tick();
        check_reset_vals();
        reset = 1'b0;
        bus.l2_ack = 1'b1;
        bus.l2_rdata = 32'hCAFE_F00D;
        tick();
        bus.l2_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_eq("late_ack_resp", 64'(bus.resp_valid), 64'(0));
            check_eq("late_ack_grant", 64'(bus.grant), 64'(0));
            check_eq("late_ack_l2req", 64'(bus.l2_rd_req), 64'(0));
            tick();
        end
        model_rr = 0;

        // fairness: cores 0, 1, 3 request continuously (upgrades, no hits)
        bus.req = 4'b1011;
        for (int k = 0; k < N; k++) begin
            bus.core_op[k]   = 2'b01;
            bus.core_addr[k] = A'($urandom);
        end
        prev = '0;
        for (int c = 0; c < 60 && seen.size() < 4; c++) begin
            tick();
            check_eq("grant_onehot0", 64'($countones(bus.grant) <= 1), 64'(1));
            if (bus.grant != '0 && prev == '0) begin
                g = -1;
                for (int k = 0; k < N; k++) if (bus.grant[k]) g = k;
                seen.push_back(g);
            end
            prev = bus.grant;
        end
        bus.req = '0;
        check_eq("fair_grant_count", 64'(seen.size()), 64'(4));
        ptr = model_rr;
        for (int i = 0; i < 4; i++) begin
            g = model_pick(4'b1011, ptr);
            if (i < seen.size()) check_eq("fair_order", 64'(seen[i]), 64'(g));
            ptr = (g + 1) % N;
        end
        repeat (8) tick();
        check_eq("fair_drain_grant", 64'(bus.grant), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
